// File: rtl/ser_pkg.sv
// Shared types and helpers for the frame serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } ser_state_t;

  localparam int unsigned SER_DEFAULT_WIDTH = 8;

  // Counter must reach WIDTH, so it needs one more code than WIDTH-1.
  function automatic int unsigned ser_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-word holding buffer between the valid/ready input and the shifter.
module ser_hold_reg
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  input  logic             take_i,
  output logic             din_ready_o,
  output logic [WIDTH-1:0] hold_o,
  output logic             hold_full_o
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;

  // Registers only; deliberately no path from din_valid_i.
  assign din_ready_o = !full_q && !reset;
  assign hold_o      = hold_q;
  assign hold_full_o = full_q;

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (take_i) begin
      full_d = 1'b0;
    end
    if (din_valid_i && din_ready_o) begin
      hold_d = din_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// MSB-first parallel-to-serial front end for the sequence detector.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module frame_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH    = SER_DEFAULT_WIDTH,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start
);

  localparam int unsigned     CntW    = ser_cnt_w(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

  ser_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // MSB goes straight to x on load, so only the remaining bits are kept.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             fs_q, fs_d;
  logic             take;
  logic             reload_chk;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .din_i      (din),
    .din_valid_i(din_valid),
    .take_i     (take),
    .din_ready_o(din_ready),
    .hold_o     (hold),
    .hold_full_o(hold_full)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    x_d        = x_q;
    x_valid_d  = x_valid_q;
    fs_d       = 1'b0;
    take       = 1'b0;
    reload_chk = 1'b0;
`ifdef SER_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: reload_chk = 1'b1;
      SHIFT: begin
        if (cnt_q != CntLast) begin
          x_d     = shreg_q[WIDTH-2];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CntOne;
        end else begin
`ifdef SER_PARITY_EN
          state_d   = PARITY;
          x_d       = par_q;
          x_valid_d = 1'b1;
`else
          reload_chk = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: reload_chk = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

    // End of a word (or idle): pull the next word in on this same edge.
    if (reload_chk) begin
      if (hold_full) begin
        take      = 1'b1;
        shreg_d   = hold[WIDTH-2:0];
        x_d       = hold[WIDTH-1];
        x_valid_d = 1'b1;
        fs_d      = 1'b1;
        cnt_d     = CntOne;
        state_d   = SHIFT;
`ifdef SER_PARITY_EN
        par_d     = ^hold;
`endif
      end else begin
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      x_q       <= IDLE_BIT;
      x_valid_q <= 1'b0;
      fs_q      <= 1'b0;
`ifdef SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      fs_q      <= fs_d;
`ifdef SER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = fs_q;

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Parallel-to-serial front end feeding the serial bit input `x` of the sequence-detector stage.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- A one-word holding buffer lets back-to-back words stream with no gap cycles.
- Drives IDLE_BIT when no data is available, so the downstream detector always samples a defined level.

Parameters:
- WIDTH, 8, word width in bits; legal range is 2 or more.
- IDLE_BIT, 1'b0, level driven on x when no bit is being shifted.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- din  in  WIDTH  parallel word, MSB transmitted first.
- din_valid  in  1  din holds a word to transfer.
- din_ready  out  1  block can accept a word this cycle.
- x  out  1  registered serial bit to the detector.
- x_valid  out  1  x carries a data or parity bit, not idle.
- frame_start  out  1  high while x carries bit WIDTH-1 of a word.

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: x=IDLE_BIT, x_valid=0, frame_start=0, hold_full=0, state=IDLE, counter=0.
- Reset mid-word: the word in flight and the held word are discarded; no partial completion after reset.
- Handshake: transfer occurs on a posedge where din_valid=1 and din_ready=1.
- din_ready = !hold_full && !reset, combinational from registers only, with no path from din_valid.
- Accept: hold <= din, hold_full <= 1.
- FSM states: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- IDLE:
  - If hold_full: shreg <= hold, hold_full <= 0, x <= hold[WIDTH-1], x_valid <= 1, frame_start <= 1, cnt <= 1, go to SHIFT.
  - Otherwise x <= IDLE_BIT, x_valid <= 0.
- SHIFT, cnt < WIDTH: x <= next bit (MSB-first), frame_start <= 0, cnt++.
- SHIFT, cnt == WIDTH (last bit on x):
  - If hold_full: reload as in IDLE on the same edge, so the next word's MSB follows with no gap.
  - Otherwise go to IDLE and drive IDLE_BIT with x_valid=0 the following cycle.
- Latency: word accepted at edge N; its MSB is on x after edge N+1. Each word occupies exactly WIDTH x_valid cycles.
- Throughput: one word per WIDTH cycles when din_valid is held high.
- Simultaneous accept and transfer: the hold→shift move clears hold_full on edge E, so din_ready rises after E and a new accept lands on E+1 at the earliest. hold is never overwritten while full.
- Counter: cnt width is $clog2(WIDTH+1) and it never wraps beyond WIDTH.
- din changing while din_ready=0 is ignored.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: after the last data bit, a PARITY state drives one extra cycle with x = even parity (XOR of all word bits), x_valid=1, frame_start=0. The hold reload test then happens at the end of PARITY instead of at the end of the last data bit. Each word occupies WIDTH+1 cycles.
- Undefined: no PARITY state or parity logic; WIDTH cycles per word.

Decomposition:
- Shared package ser_pkg:
  - state enum ser_state_t {IDLE, SHIFT, PARITY}.
  - SER_DEFAULT_WIDTH = 8.
  - Function ser_cnt_w(width) returning the counter width.
- One natural sub-module, ser_hold_reg: the holding buffer and hold_full flag, which generates din_ready.
- Shift register, counter and FSM stay in the top module.

Test Plan:
- Reset: hold reset 3 cycles → x=0, x_valid=0, din_ready=0 during reset; din_ready=1 one cycle after release.
- Single word, WIDTH=6, din=6'b110011: x sequence is 1,1,0,0,1,1 starting two edges after accept. frame_start is high only on the first bit. x_valid is high for exactly 6 cycles, then x=IDLE_BIT. The downstream detector then asserts z.
- Back-to-back, WIDTH=8, din_valid held high with 8'hA5 then 8'h3C: 16 contiguous x_valid cycles with bits 10100101 00111100, frame_start at cycle 1 and cycle 9, no idle gap.
- Backpressure: present a third word while hold_full=1 → din_ready=0; din is ignored until the hold→shift move, then the word is accepted and sent intact.
- Reset mid-word: assert reset after 3 bits of 8'hFF → x=0 and x_valid=0 immediately (async). After release no remaining bits of the word appear, and the next word starts clean.
- With SER_PARITY_EN, WIDTH=6, din=6'b110011 → 7 x_valid cycles, 7th bit = 0. With din=6'b110010, 7th bit = 1.
